// File: rtl/handshake_constant_seq_pkg.sv
// Shared definitions for the handshake constant sequencer: index-width helpers
// and the skid-buffer state encoding.
package handshake_constant_seq_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single-entry table still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/handshake_skid_buffer.sv
// Two-entry skid buffer: in_ready is a function of registered state only,
// so there is no combinational path from out_ready back to in_ready.
module handshake_skid_buffer
  import handshake_constant_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  skid_state_t           r_state;
  skid_state_t           w_next_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_skid_to_main;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SKID_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_skid_to_main)
        r_main <= r_skid;
      else if (w_load_main)
        r_main <= in_data;
      if (w_load_skid)
        r_skid <= in_data;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SKID_EMPTY: if (w_accept) w_next_state = SKID_ONE;
      SKID_ONE: begin
        if (w_accept && !w_pop)      w_next_state = SKID_FULL;
        else if (w_pop && !w_accept) w_next_state = SKID_EMPTY;
      end
      SKID_FULL:  if (w_pop) w_next_state = SKID_ONE;
      default:    w_next_state = SKID_EMPTY;
    endcase
  end

  always_comb begin
    out_valid      = (r_state != SKID_EMPTY);
    in_ready       = (r_state != SKID_FULL) && (r_state != SKID_EMPTY || 1'b1) && !rst;
    out_data       = r_main;
    w_accept       = in_valid && in_ready;
    w_pop          = out_valid && out_ready;
    // Main register refills when free or draining this cycle; skid only catches a stalled accept.
    w_load_main    = w_accept && ((r_state == SKID_EMPTY) || w_pop);
    w_load_skid    = w_accept && !w_pop && (r_state == SKID_ONE);
    w_skid_to_main = (r_state == SKID_FULL) && w_pop;
  end

endmodule

// File: rtl/handshake_constant_seq.sv
// Emits one word from a constant table per accepted control token, cycling
// through the table with wrap and an optional synchronous restart to entry 0.
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int                               DATA_WIDTH  = 32,
  parameter int                               NUM_CONSTS  = 4,
  parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_TABLE = '0,
  localparam int                              IDX_W       = idx_w(NUM_CONSTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  input  logic                  restart,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [IDX_W-1:0]      cur_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSTS - 1);

  logic [DATA_WIDTH-1:0] w_table [NUM_CONSTS];
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_eff_idx;
  logic [IDX_W-1:0]      w_next_idx;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_accept;

  for (genvar g = 0; g < NUM_CONSTS; g++) begin : g_table
    assign w_table[g] = CONST_TABLE[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Restart applies to the token accepted in the same cycle, not just the next one.
  assign w_eff_idx  = restart ? '0 : r_idx;
  assign w_next_idx = (w_eff_idx == LAST_IDX) ? '0 : w_eff_idx + IDX_W'(1);
  assign w_word     = w_table[w_eff_idx];
  assign w_accept   = ctrl_valid && ctrl_ready;
  assign cur_index  = r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_idx <= '0;
    else if (w_accept)
      r_idx <= w_next_idx;
    else if (restart)
      r_idx <= '0;
  end

  handshake_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ctrl_valid),
    .in_ready  (ctrl_ready),
    .in_data   (w_word),
    .out_valid (outs_valid),
    .out_ready (outs_ready),
    .out_data  (outs)
  );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed bench for handshake_constant_seq: a 3-entry table instance and a
// single-entry instance, driven as one linear sequence of steps.
module tb_handshake_constant_seq;

  logic       clk = 1'b0;
  logic       rst;

  logic       c0_valid, c0_ready, r0_restart, o0_valid, o0_ready;
  logic [7:0] o0_data;
  logic [1:0] idx0;

  logic       c1_valid, c1_ready, r1_restart, o1_valid, o1_ready;
  logic [7:0] o1_data;
  logic [0:0] idx1;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] exp_seq [3] = '{8'h0A, 8'h0B, 8'h0C};

  always #5 clk = ~clk;

  handshake_constant_seq #(
    .DATA_WIDTH (8),
    .NUM_CONSTS (3),
    .CONST_TABLE({8'h0C, 8'h0B, 8'h0A})
  ) u0 (
    .clk(clk), .rst(rst), .ctrl_valid(c0_valid), .ctrl_ready(c0_ready),
    .restart(r0_restart), .outs(o0_data), .outs_valid(o0_valid),
    .outs_ready(o0_ready), .cur_index(idx0)
  );

  handshake_constant_seq #(
    .DATA_WIDTH (8),
    .NUM_CONSTS (1),
    .CONST_TABLE(8'h5A)
  ) u1 (
    .clk(clk), .rst(rst), .ctrl_valid(c1_valid), .ctrl_ready(c1_ready),
    .restart(r1_restart), .outs(o1_data), .outs_valid(o1_valid),
    .outs_ready(o1_ready), .cur_index(idx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int         cnt, acc_n, pop_n;
  logic       prev_stall;
  logic [7:0] prev_outs;
  logic       cr0, cr1;

  initial begin
    rst = 1'b1;
    c0_valid = 0; r0_restart = 0; o0_ready = 0;
    c1_valid = 0; r1_restart = 0; o1_ready = 0;
    tick; tick;

    // Reset state
    check("rst_valid", o0_valid, 0);
    check("rst_outs", o0_data, 0);
    check("rst_idx", idx0, 0);
    check("rst_ready", c0_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", c0_ready, 1);

    // Streaming at full throughput
    c0_valid = 1; o0_ready = 1;
    for (int i = 0; i < 7; i++) begin
      check("s1_idx", idx0, i % 3);
      check("s1_ready", c0_ready, 1);
      tick;
      check("s1_valid", o0_valid, 1);
      check("s1_outs", o0_data, exp_seq[i % 3]);
    end
    c0_valid = 0;
    tick;
    check("s1_drain", o0_valid, 0);
    check("s1_idx_end", idx0, 1);
    r0_restart = 1;
    tick;
    r0_restart = 0;
    check("restart_alone", idx0, 0);

    // Back-pressure fills main then skid
    c0_valid = 1; o0_ready = 0;
    tick;
    check("s2_outs1", o0_data, 8'h0A);
    check("s2_ready1", c0_ready, 1);
    tick;
    check("s2_ready_full", c0_ready, 0);
    check("s2_outs2", o0_data, 8'h0A);
    check("s2_idx2", idx0, 2);
    tick;
    check("s2_ignored_idx", idx0, 2);
    check("s2_hold", o0_data, 8'h0A);
    o0_ready = 1;
    #0;
    check("s2_no_comb", c0_ready, 0);
    c0_valid = 0;
    tick;
    check("s2_second", o0_data, 8'h0B);
    check("s2_second_v", o0_valid, 1);
    tick;
    check("s2_empty", o0_valid, 0);
    c0_valid = 1;
    tick;
    check("s2_third", o0_data, 8'h0C);
    c0_valid = 0;
    tick;
    check("s2_idx_wrap", idx0, 0);

    // Restart together with an accept, then restart alone with words buffered
    c0_valid = 1; o0_ready = 1;
    tick; tick;
    check("s3_idx2", idx0, 2);
    r0_restart = 1;
    tick;
    r0_restart = 0;
    check("s3_restart_word", o0_data, 8'h0A);
    check("s3_restart_idx", idx0, 1);
    o0_ready = 0;
    tick;
    check("s3_full", c0_ready, 0);
    c0_valid = 0; r0_restart = 1;
    tick;
    r0_restart = 0;
    check("s3_idx0", idx0, 0);
    check("s3_main_kept", o0_data, 8'h0A);
    o0_ready = 1;
    tick;
    check("s3_skid_kept", o0_data, 8'h0B);
    tick;
    check("s3_empty", o0_valid, 0);

    // Random traffic against an occupancy / order model
    cnt = 0; acc_n = 0; pop_n = 0; prev_stall = 0; prev_outs = '0;
    for (int i = 0; i < 303; i++) begin
      c0_valid = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      o0_ready = 0;
      #0 cr0 = c0_ready;
      o0_ready = 1;
      #0 cr1 = c0_ready;
      check("r_comb", cr1, cr0);
      o0_ready = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      #0;
      check("r_ready", c0_ready, (cnt < 2));
      check("r_valid", o0_valid, (cnt > 0));
      check("r_idx", idx0, acc_n % 3);
      if (prev_stall) check("r_stable", o0_data, prev_outs);
      if (o0_valid && o0_ready) begin
        check("r_order", o0_data, exp_seq[pop_n % 3]);
        pop_n++;
      end
      if (c0_valid && c0_ready) acc_n++;
      cnt = acc_n - pop_n;
      prev_stall = o0_valid & ~o0_ready;
      prev_outs  = o0_data;
      tick;
    end
    check("r_no_loss", pop_n, acc_n);

    // Asynchronous reset while full
    c0_valid = 1; o0_ready = 0;
    tick; tick;
    check("s5_full", c0_ready, 0);
    c0_valid = 0;
    #3;
    rst = 1'b1;
    #1;
    check("s5_valid", o0_valid, 0);
    check("s5_outs", o0_data, 0);
    check("s5_idx", idx0, 0);
    check("s5_ready", c0_ready, 0);
    tick;
    rst = 1'b0;
    c0_valid = 1; o0_ready = 1;
    tick;
    check("s5_first", o0_data, 8'h0A);
    check("s5_first_v", o0_valid, 1);
    c0_valid = 0;
    tick;

    // Single-entry table
    c1_valid = 1; o1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("s6_idx", idx1, 0);
      check("s6_ready", c1_ready, 1);
      tick;
      check("s6_valid", o1_valid, 1);
      check("s6_outs", o1_data, 8'h5A);
    end
    c1_valid = 0;
    tick;
    check("s6_empty", o1_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
